// File: rtl/mem_port_arb_if.sv
// Handshake bundle between the two pipeline requesters, the memory port and
// the memory-port arbiter.
interface mem_port_arb_if;
  logic req0;
  logic req1;
  logic mem_ready;
  logic sel;
  logic mem_req;
  logic done0;
  logic done1;
  logic stall0;
  logic stall1;

  // Requesters and memory drive requests/ready and observe grants.
  modport master (
    output req0, req1, mem_ready,
    input  sel, mem_req, done0, done1, stall0, stall1
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, mem_ready,
    output sel, mem_req, done0, done1, stall0, stall1
  );
endinterface

// File: rtl/mem_port_arb.sv
// Two-requester arbiter for the unified memory port: data (req1) has
// priority, fetch (req0) is guaranteed a grant after STARVE_LIMIT
// consecutive data grants made while it waits.
module mem_port_arb #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_port_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // State, mux select and starvation counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until mem_ready.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.req0) begin
          starve_cnt_d = '0;
        end
        if (bus.req1 && !(bus.req0 && starve_cnt_q == LIMIT)) begin
          state_d = BUSY1;
          sel_d   = 1'b1;
        end else if (bus.req0) begin
          state_d      = BUSY0;
          sel_d        = 1'b0;
          starve_cnt_d = '0;
        end
      end
      BUSY0: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end
      BUSY1: begin
        if (bus.mem_ready) begin
          state_d = IDLE;
          if (bus.req0 && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: mem_req/sel come straight from registers; done/stall are
  // combinational so completion is visible in the mem_ready cycle.
  always_comb begin
    bus.sel     = sel_q;
    bus.mem_req = (state_q != IDLE);
    bus.done0   = (state_q == BUSY0) && bus.mem_ready;
    bus.done1   = (state_q == BUSY1) && bus.mem_ready;
    bus.stall0  = bus.req0 && !((state_q == BUSY0) && bus.mem_ready);
    bus.stall1  = bus.req1 && !((state_q == BUSY1) && bus.mem_ready);
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Sequential arbiter sharing the single unified memory port of the pipelined RISC-V core between the instruction-fetch stage (requester 0) and the MEM stage (requester 1). It owns the select line of the 2:1 address/data mux in front of the memory: sel=0 routes the fetch path (mux input A) and sel=1 routes the data path (mux input B). It also sequences multi-cycle memory transactions and produces per-requester stall and completion signals. Data accesses take priority, and a bounded starvation counter guarantees that fetch eventually wins.

## Interface
- STARVE_LIMIT, 4: number of consecutive data grants, made while fetch is waiting, after which fetch wins the next tie.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Asynchronous, active-high.
- req0  in  1  fetch request. Held high until done0.
- req1  in  1  data request. Held high until done1.
- mem_ready  in  1  memory completes the current transaction this cycle.
- sel  out  1  mux select. 0 = fetch (A), 1 = data (B). Constant for the whole transaction.
- mem_req  out  1  transaction active toward memory.
- done0  out  1  one-cycle completion pulse for fetch.
- done1  out  1  one-cycle completion pulse for data.
- stall0  out  1  fetch must hold: req0 & ~done0.
- stall1  out  1  data must hold: req1 & ~done1.

## Operation
- States: IDLE, BUSY0, BUSY1. State is registered.
- IDLE:
  - No request: stay in IDLE.
  - req1 only: go to BUSY1.
  - req0 only: go to BUSY0.
  - Both requests: go to BUSY1, unless starve_cnt == STARVE_LIMIT, in which case go to BUSY0.
- BUSYx:
  - mem_req=1 and sel=x, both registered.
  - On mem_ready, go to IDLE.
  - Otherwise stay in BUSYx with the same sel, regardless of request changes.
- Output decode:
  - done0 = (state==BUSY0) & mem_ready.
  - done1 = (state==BUSY1) & mem_ready.
  - Both are combinational from mem_ready.
- sel in IDLE holds its last value. It never toggles without a grant, so the mux output does not glitch.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on done1 when req0 is high.
  - Clears on entry to BUSY0 and whenever req0 is low in IDLE.
- mem_ready asserted in IDLE is ignored: no done pulse, no state change.
- A request dropped mid-transaction is a protocol violation. The transaction still runs to mem_ready and the done pulse is still generated.

## Timing
- Reset values (asynchronous, effective immediately):
  - state=IDLE, sel=0, mem_req=0, starve_cnt=0.
  - done0=done1=0.
  - stall0=req0 and stall1=req1.
- Latency:
  - A request seen in IDLE at edge N gives mem_req=1 and the chosen sel after edge N.
  - Minimum transaction is 2 cycles (grant cycle, then mem_ready in the next cycle).
- Back-to-back:
  - After done, one IDLE bubble cycle is mandatory before the next grant.
  - A requester that re-asserts immediately is arbitrated in that bubble.
- Same-cycle events:
  - Request arrival and done of the other requester: the new request waits for IDLE.
  - mem_ready and rst in the same cycle: reset wins and no done is recorded.
- Reset mid-transaction: mem_req drops asynchronously and the transaction is abandoned. Memory is reset by the same rst.

## Test plan
- Reset during BUSY1 with mem_ready low -> sel=0, mem_req=0, done1 never pulses, and the state reads IDLE on the next cycle.
- req0 alone, mem_ready after 3 cycles -> mem_req high for 3 cycles with sel=0, done0 pulses exactly once, stall0 low on the done cycle.
- req0 and req1 asserted together from reset -> BUSY1 granted first (sel=1). After done1 and one bubble, BUSY0 is granted (sel=0).
- req1 held continuously with req0 waiting, STARVE_LIMIT=4, mem_ready every 2nd cycle -> 4 data grants, then the fetch grant. starve_cnt reads 4 before the fetch grant and 0 after entry to BUSY0.
- mem_ready pulsed in IDLE with no requests -> no done pulse, sel unchanged, mem_req stays 0.
- During BUSY0, req1 rises while mem_ready is held low for 5 cycles -> sel stays 0 and stall1=1 throughout. BUSY1 is granted in the bubble after done0.
